// File: rtl/tone_pkg.sv
// Shared definitions for the tone scheduler: FSM states, requester ids,
// millisecond divider and half-period arithmetic.
package tone_pkg;

    localparam int unsigned HALF_W = 27;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        ENGINE = 1'b0,
        CRASH  = 1'b1
    } req_id_t;

    // Clock cycles per millisecond.
    function automatic int unsigned ms_div(input int unsigned clk_hz);
        return clk_hz / 1000;
    endfunction

    // Half period in clock cycles, floored, never below 1.
    // A zero frequency yields 1 so the divider never sees zero.
    function automatic logic [HALF_W-1:0] calc_half(input int unsigned clk_hz,
                                                     input logic [31:0] freq);
        logic [31:0] q;
        if (freq == '0) begin
            q = 32'd1;
        end else begin
            q = clk_hz / (freq << 1);
        end
        if (q == '0) begin
            q = 32'd1;
        end
        return q[HALF_W-1:0];
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: half-period counter plus the tone flip-flop.
// Clear has priority over load, load over enable.
module tone_gen
    import tone_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              load,
    input  logic              clear,
    input  logic [HALF_W-1:0] half,
    output logic              tone
);

    logic [HALF_W-1:0] half_q;
    logic [HALF_W-1:0] cnt;

    // Half-period counter; the output toggles each time it completes a half period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            half_q <= '0;
            cnt    <= '0;
            tone   <= 1'b0;
        end else if (clear) begin
            cnt    <= '0;
            tone   <= 1'b0;
        end else if (load) begin
            half_q <= half;
            cnt    <= '0;
            tone   <= 1'b0;
        end else if (enable) begin
            if (cnt == half_q - HALF_W'(1)) begin
                cnt  <= '0;
                tone <= ~tone;
            end else begin
                cnt  <= cnt + HALF_W'(1);
            end
        end
    end

endmodule

// File: rtl/tone_scheduler.sv
// Arbitrates one tone generator between engine (low) and crash (high)
// requesters, times each play in milliseconds and pulses completion.
module tone_scheduler
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned FREQ_W = 11,
    parameter int unsigned DUR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [FREQ_W-1:0] freq0,
    input  logic [FREQ_W-1:0] freq1,
    input  logic [DUR_W-1:0]  dur0,
    input  logic [DUR_W-1:0]  dur1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic              busy,
    output logic              tone
);

    localparam int unsigned MS_DIV = ms_div(CLK_HZ);
    localparam int unsigned PRE_W  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

    state_t            state;
    state_t            next_state;
    req_id_t           owner;
    req_id_t           grant_id;
    logic              grant;
    logic [FREQ_W-1:0] grant_freq;
    logic [DUR_W-1:0]  grant_dur;
    logic [DUR_W-1:0]  rem;
    logic [PRE_W-1:0]  pre;
    logic              pre_wrap;
    logic              finish;
    logic              audible;
    logic [HALF_W-1:0] grant_half;

    assign pre_wrap   = (pre == PRE_W'(MS_DIV - 1));
    // The play ends on the prescaler wrap that brings the ms count to zero,
    // so PLAY lasts exactly dur*MS_DIV cycles (one cycle when dur is 0).
    assign finish     = (rem == '0) || ((rem == DUR_W'(1)) && pre_wrap);
    assign grant_freq = (grant_id == CRASH) ? freq1 : freq0;
    assign grant_dur  = (grant_id == CRASH) ? dur1  : dur0;
    assign grant_half = calc_half(CLK_HZ, 32'(grant_freq));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and grant decision, including crash preemption of the engine.
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        grant_id   = ENGINE;
        case (state)
            IDLE: begin
                if (req != '0) begin
                    grant      = 1'b1;
                    grant_id   = req[CRASH] ? CRASH : ENGINE;
                    next_state = PLAY;
                end
            end
            PLAY: begin
                if ((owner == ENGINE) && req[CRASH]) begin
                    grant    = 1'b1;
                    grant_id = CRASH;
                end else if (finish) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from the current state and owner.
    always_comb begin
        gnt  = '0;
        done = '0;
        busy = (state != IDLE);
        if (state == PLAY) begin
            gnt = (owner == CRASH) ? 2'b10 : 2'b01;
        end else if (state == DONE) begin
            done = (owner == CRASH) ? 2'b10 : 2'b01;
        end
    end

    // Grant-time latches, millisecond prescaler and remaining-ms counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner   <= ENGINE;
            rem     <= '0;
            pre     <= '0;
            audible <= 1'b0;
        end else if (grant) begin
            owner   <= grant_id;
            rem     <= grant_dur;
            pre     <= '0;
            audible <= (grant_freq != '0);
        end else if (state == PLAY) begin
            if (pre_wrap) begin
                pre <= '0;
                if (rem != '0) begin
                    rem <= rem - DUR_W'(1);
                end
            end else begin
                pre <= pre + PRE_W'(1);
            end
        end else begin
            pre <= '0;
        end
    end

    tone_gen u_tone_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable ((state == PLAY) && audible),
        .load   (grant),
        .clear  (next_state != PLAY),
        .half   (grant_half),
        .tone   (tone)
    );

endmodule
